// File: rtl/regfile_mp.sv
// Two-write / two-read register file with fixed W1-over-W0 priority, optional
// write-to-read bypass, optional hardwired zero entry and a soft-clear sweep.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              RF_clk,
    input  logic              RF_rst,
    input  logic              RF_ena,
    input  logic              RF_clr,
    input  logic              W0_en,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic [DATA_W-1:0] W0_data,
    input  logic              W1_en,
    input  logic [ADDR_W-1:0] W1_addr,
    input  logic [DATA_W-1:0] W1_data,
    input  logic [ADDR_W-1:0] Rsc,
    input  logic [ADDR_W-1:0] Rtc,
    output logic [DATA_W-1:0] Rs,
    output logic [DATA_W-1:0] Rt,
    output logic              clr_busy,
    output logic              wr_drop
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_open, w0_ok, w1_ok;

    // Entry 0 is unwritable and reads zero when the zero register is enabled.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_open = (state_q == IDLE) && RF_ena;
    assign w0_ok   = wr_open && W0_en && addr_ok(W0_addr);
    assign w1_ok   = wr_open && W1_en && addr_ok(W1_addr);

    function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] stored);
        if (!RF_ena || (state_q == CLEAR) || !addr_ok(a)) return '0;
        if ((BYPASS != 0) && w1_ok && (W1_addr == a)) return W1_data;
        if ((BYPASS != 0) && w0_ok && (W0_addr == a)) return W0_data;
        return stored;
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_drop_d = (state_q == CLEAR) && (W0_en || W1_en);
        mem_d     = mem_q;
        case (state_q)
            IDLE: begin
                // W1 is applied last so it wins a same-address collision.
                if (w0_ok) mem_d[W0_addr] = W0_data;
                if (w1_ok) mem_d[W1_addr] = W1_data;
                if (RF_clr && RF_ena) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            CLEAR: begin
                if (RF_ena) begin
                    mem_d[clr_idx_q] = '0;
                    clr_idx_d        = clr_idx_q + ADDR_W'(1);
                    if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge RF_clk) begin
        if (RF_rst) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            wr_drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            wr_drop_q <= wr_drop_d;
            mem_q     <= mem_d;
        end
    end

    always_comb begin
        Rs = rd_port(Rsc, mem_q[Rsc]);
        Rt = rd_port(Rtc, mem_q[Rtc]);
    end

    assign clr_busy = (state_q == CLEAR);
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: one instance with zero register and bypass,
// one without, both checked every cycle against a behavioural model.
module tb_regfile_mp;
    logic        RF_clk = 1'b0;
    logic        RF_rst, RF_ena, RF_clr;
    logic        W0_en, W1_en;
    logic [4:0]  W0_addr, W1_addr, Rsc, Rtc;
    logic [31:0] W0_data, W1_data;
    logic [31:0] Rs_a, Rt_a, Rs_b, Rt_b;
    logic        busy_a, drop_a, busy_b, drop_b;

    int vectors = 0;
    int errors  = 0;

    always #5 RF_clk = ~RF_clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_a (
        .RF_clk(RF_clk), .RF_rst(RF_rst), .RF_ena(RF_ena), .RF_clr(RF_clr),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
        .W1_en(W1_en), .W1_addr(W1_addr), .W1_data(W1_data),
        .Rsc(Rsc), .Rtc(Rtc), .Rs(Rs_a), .Rt(Rt_a),
        .clr_busy(busy_a), .wr_drop(drop_a));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
        .RF_clk(RF_clk), .RF_rst(RF_rst), .RF_ena(RF_ena), .RF_clr(RF_clr),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
        .W1_en(W1_en), .W1_addr(W1_addr), .W1_data(W1_data),
        .Rsc(Rsc), .Rtc(Rtc), .Rs(Rs_b), .Rt(Rt_b),
        .clr_busy(busy_b), .wr_drop(drop_b));

    // Behavioural model: plain arrays plus sweep position.
    logic [31:0] mA [32];
    logic [31:0] mB [32];
    bit          m_busy = 0, m_drop = 0, armed = 0;
    int          m_idx = 0;

    always @(posedge RF_clk) begin
        if (RF_rst) begin
            for (int i = 0; i < 32; i++) begin mA[i] = 0; mB[i] = 0; end
            m_busy = 0; m_drop = 0; m_idx = 0; armed = 1;
        end else begin
            m_drop = m_busy && (W0_en || W1_en);
            if (m_busy) begin
                if (RF_ena) begin
                    mA[m_idx] = 0; mB[m_idx] = 0;
                    if (m_idx == 31) m_busy = 0;
                    m_idx = (m_idx + 1) % 32;
                end
            end else if (RF_ena) begin
                if (W0_en) begin
                    if (W0_addr != 0) mA[W0_addr] = W0_data;
                    mB[W0_addr] = W0_data;
                end
                if (W1_en) begin
                    if (W1_addr != 0) mA[W1_addr] = W1_data;
                    mB[W1_addr] = W1_data;
                end
                if (RF_clr) begin m_busy = 1; m_idx = 0; end
            end
        end
    end

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (!RF_ena || m_busy || a == 0) return 0;
        if (W1_en && W1_addr == a) return W1_data;
        if (W0_en && W0_addr == a) return W0_data;
        return mA[a];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] a);
        if (!RF_ena || m_busy) return 0;
        return mB[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge RF_clk) begin
        if (armed && !RF_rst) begin
            chk("Rs_a", Rs_a, exp_a(Rsc));
            chk("Rt_a", Rt_a, exp_a(Rtc));
            chk("Rs_b", Rs_b, exp_b(Rsc));
            chk("Rt_b", Rt_b, exp_b(Rtc));
            chk("busy_a", 32'(busy_a), 32'(m_busy));
            chk("busy_b", 32'(busy_b), 32'(m_busy));
            chk("drop_a", 32'(drop_a), 32'(m_drop));
            chk("drop_b", 32'(drop_b), 32'(m_drop));
        end
    end

    task automatic tick();
        @(posedge RF_clk);
        #1;
    endtask

    task automatic quiet();
        RF_rst = 0; RF_clr = 0; W0_en = 0; W1_en = 0;
    endtask

    task automatic fill();
        for (int i = 1; i < 32; i++) begin
            W0_en = 1; W0_addr = 5'(i); W0_data = 32'h0101_0101 * i;
            tick();
        end
        W0_en = 0;
    endtask

    task automatic sweep(input int stall_at, input int mid_wr, input int mid_clr,
                         output int n);
        RF_clr = 1; tick(); RF_clr = 0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy_a) break;
            n++;
            if (i == stall_at) RF_ena = 0;
            if (i == stall_at + 1) begin
                Rsc = 5'd9; #1;
                chk("stall_rs_a", Rs_a, 0);
                chk("stall_rs_b", Rs_b, 0);
            end
            if (i == stall_at + 5) RF_ena = 1;
            if (i == mid_wr) begin W1_en = 1; W1_addr = 5'd9; W1_data = 32'h9999_9999; end
            if (i == mid_wr + 1) begin chk("mid_drop", 32'(drop_a), 1); W1_en = 0; end
            if (i == mid_clr) RF_clr = 1;
            if (i == mid_clr + 1) RF_clr = 0;
            if (i == 199) chk("sweep_timeout", 32'(busy_a), 0);
            tick();
        end
        RF_ena = 1;
    endtask

    initial begin
        int n;
        RF_ena = 1; quiet(); RF_rst = 1;
        W0_addr = 0; W1_addr = 0; W0_data = 0; W1_data = 0; Rsc = 0; Rtc = 0;
        tick(); tick();
        RF_rst = 0;

        // Reset clears a written entry.
        W0_en = 1; W0_addr = 5; W0_data = 32'hDEAD_BEEF; tick(); W0_en = 0;
        Rsc = 5; #1; chk("pre_rst_r5", Rs_a, 32'hDEAD_BEEF);
        RF_rst = 1; tick(); RF_rst = 0; #1;
        chk("rst_r5", Rs_a, 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_drop", 32'(drop_a), 0);

        // Priority and single write.
        W0_en = 1; W0_addr = 3; W0_data = 32'h1111_1111;
        W1_en = 1; W1_addr = 3; W1_data = 32'h2222_2222; tick(); quiet();
        Rsc = 3; #1; chk("prio_a", Rs_a, 32'h2222_2222); chk("prio_b", Rs_b, 32'h2222_2222);
        W0_en = 1; W0_addr = 4; W0_data = 32'hA5A5_A5A5; tick(); quiet();
        Rtc = 4; #1; chk("w0_a", Rt_a, 32'hA5A5_A5A5); chk("w0_b", Rt_b, 32'hA5A5_A5A5);

        // Zero register.
        W1_en = 1; W1_addr = 0; W1_data = 32'hFFFF_FFFF; Rsc = 0; #1;
        chk("zero_same_a", Rs_a, 0); chk("zero_same_b", Rs_b, 0);
        tick(); quiet(); #1;
        chk("zero_next_a", Rs_a, 0); chk("zero_next_b", Rs_b, 32'hFFFF_FFFF);
        chk("zero_drop", 32'(drop_a), 0);

        // Bypass.
        W0_en = 1; W0_addr = 7; W0_data = 32'h0000_1234; tick(); quiet();
        Rsc = 7; Rtc = 7; W0_en = 1; W0_addr = 7; W0_data = 32'h0000_CAFE; #1;
        chk("byp_rs_a", Rs_a, 32'h0000_CAFE); chk("byp_rt_a", Rt_a, 32'h0000_CAFE);
        chk("byp_rs_b", Rs_b, 32'h0000_1234);
        tick(); quiet(); #1; chk("byp_next_b", Rs_b, 32'h0000_CAFE);

        // Disabled block reads zero.
        RF_ena = 0; Rsc = 4; #1; chk("dis_a", Rs_a, 0); chk("dis_b", Rs_b, 0); RF_ena = 1;

        // Sweep with a dropped write and a second clear request.
        fill();
        sweep(1000, 3, 5, n);
        chk("sweep_len", n, 32);
        Rsc = 9; #1; chk("r9_a", Rs_a, 0); chk("r9_b", Rs_b, 0);

        // Stalled sweep.
        fill();
        sweep(10, 1000, 1000, n);
        chk("stall_len", n, 37);

        // Reset in the middle of a sweep.
        fill();
        RF_clr = 1; tick(); RF_clr = 0;
        for (int i = 0; i < 8; i++) tick();
        RF_rst = 1; tick(); RF_rst = 0; #1;
        chk("midrst_busy", 32'(busy_a), 0);
        Rsc = 20; Rtc = 31; #1;
        chk("midrst_r20", Rs_b, 0); chk("midrst_r31", Rt_b, 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            RF_ena  = ($urandom % 8) != 0;
            RF_rst  = ($urandom % 400) == 0;
            RF_clr  = ($urandom % 80) == 0;
            W0_en   = $urandom % 2;
            W1_en   = $urandom % 2;
            W0_addr = ($urandom % 2) ? 5'($urandom % 4) : 5'($urandom);
            W1_addr = ($urandom % 3 == 0) ? W0_addr : 5'($urandom % 8);
            W0_data = $urandom;
            W1_data = $urandom;
            Rsc     = ($urandom % 2) ? W0_addr : 5'($urandom);
            Rtc     = ($urandom % 2) ? W1_addr : 5'($urandom % 8);
            tick();
        end
        quiet(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, next generation of the CPU31 single-write register file. It provides two write ports with fixed priority and two asynchronous read ports. Optional write-to-read bypass and an optional hardwired zero register are selected by parameter. A multi-cycle soft-clear sequencer lets the pipeline wipe the file without asserting global reset.

Parameters:
DATA_W  32  width of each register in bits
ADDR_W  5  address width; DEPTH = 2**ADDR_W entries
ZERO_REG  1  1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register
BYPASS  1  1: a same-cycle write is forwarded to matching read ports; 0: reads show stored contents only

Ports:
RF_clk  in  1  clock; all state updates on the rising edge
RF_rst  in  1  synchronous reset, active-high
RF_ena  in  1  block enable; when 0, writes are ignored and read outputs are 0
RF_clr  in  1  single-cycle pulse that starts the soft-clear sweep
W0_en  in  1  write port 0 enable
W0_addr  in  ADDR_W  write port 0 address
W0_data  in  DATA_W  write port 0 data
W1_en  in  1  write port 1 enable; higher priority than port 0
W1_addr  in  ADDR_W  write port 1 address
W1_data  in  DATA_W  write port 1 data
Rsc  in  ADDR_W  read port A address
Rtc  in  ADDR_W  read port B address
Rs  out  DATA_W  read port A data, combinational
Rt  out  DATA_W  read port B data, combinational
clr_busy  out  1  high while the soft-clear sweep is running
wr_drop  out  1  registered; 1 for one cycle after an enabled write was discarded

Behaviour:
- Reset: a cycle with RF_rst=1 at the edge zeroes all DEPTH entries in that single edge.
  - clr_busy=0, wr_drop=0, FSM enters IDLE.
  - RF_rst overrides RF_clr and all writes, including when a sweep is in progress.
- Write, FSM=IDLE and RF_ena=1:
  - W0_en=1 writes W0_data to W0_addr at the edge; W1_en=1 writes W1_data to W1_addr.
  - If both ports target the same address, W1 wins and W0 is discarded silently (wr_drop stays 0).
  - Address 0 with ZERO_REG=1 is discarded silently.
- Read:
  - Rs = entry[Rsc], Rt = entry[Rtc], with no clock latency.
  - Address 0 with ZERO_REG=1 reads 0.
  - RF_ena=0 forces Rs=Rt=0. The outputs are never tristated.
- Bypass (BYPASS=1): if a write commits at the coming edge to an address equal to Rsc or Rtc, that read port shows the write data in the same cycle.
  - If both ports match, W1 data is shown.
  - There is no bypass for address 0 when ZERO_REG=1, and no bypass when FSM=CLEAR.
- FSM states: IDLE and CLEAR, with a counter clr_idx of ADDR_W bits.
  - IDLE -> CLEAR when RF_clr=1 and RF_ena=1: clr_idx<=0, clr_busy<=1.
  - In CLEAR, each edge writes entry[clr_idx]<=0 and increments clr_idx.
  - When clr_idx==DEPTH-1, that entry is cleared, the FSM goes CLEAR -> IDLE and clr_busy<=0.
  - The sweep takes exactly DEPTH cycles, and clr_busy is high for exactly DEPTH cycles.
  - RF_clr asserted while in CLEAR is ignored; the sweep does not restart.
  - RF_ena=0 during CLEAR stalls the sweep: clr_idx holds and clr_busy stays 1.
- During CLEAR:
  - Rs and Rt read 0 regardless of address.
  - Any W0_en or W1_en is discarded, and wr_drop<=1 on the next edge.
- wr_drop is 0 in every other cycle.
- Arithmetic: clr_idx wraps naturally at DEPTH-1; the terminal compare is used, not overflow.

Test Plan:
- Reset: RF_rst=1 for 1 cycle after writing 0xDEADBEEF to r5 -> next cycle Rsc=5 gives Rs=0, clr_busy=0, wr_drop=0.
- Basic and priority:
  - W0 writes r3=0x11111111 and W1 writes r3=0x22222222 in the same cycle -> Rsc=3 next cycle gives 0x22222222.
  - W0 writes r4=0xA5A5A5A5 alone -> Rtc=4 gives 0xA5A5A5A5.
- Zero register: ZERO_REG=1, W1 writes r0=0xFFFFFFFF -> Rs(Rsc=0)=0 in the same and next cycle, wr_drop=0. With ZERO_REG=0 the same stimulus gives 0xFFFFFFFF next cycle.
- Bypass: BYPASS=1, Rsc=Rtc=7, W0 writes r7=0x0000CAFE in cycle t -> Rs=Rt=0x0000CAFE during cycle t. BYPASS=0 shows the old value in cycle t and 0x0000CAFE at t+1.
- Soft clear:
  - Fill r1..r31 with nonzero values, pulse RF_clr -> clr_busy high exactly 32 cycles, then every register reads 0.
  - A W1 write to r9 mid-sweep -> wr_drop=1 the next cycle and r9=0 after the sweep.
  - A second RF_clr mid-sweep -> sweep length unchanged.
- Stall and reset mid-clear:
  - RF_ena=0 for 5 cycles mid-sweep -> clr_busy high for 37 cycles total, Rs=Rt=0 while disabled.
  - RF_rst mid-sweep -> clr_busy=0 next cycle and all entries 0.
